// File: rtl/stable_serial_tx_if.sv
// Upstream valid/ready word handshake for stable_serial_tx.
// The producer owns the word and valid; the transmitter owns ready.
interface stable_serial_tx_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/stable_serial_tx.sv
// Single-wire framed transmitter: start(1), WIDTH data bits MSB first, stop(0),
// every line level held for HOLD cycles so a 4-sample receive filter passes it cleanly.
module stable_serial_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned HOLD  = 8
) (
    input  logic              clock,
    input  logic              reset,
    stable_serial_tx_if.slave up,
    output logic              sig_out,
    output logic              busy,
    output logic              done
);
    localparam int unsigned HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state;
    logic [HCW-1:0]   hold_cnt;
    logic [BCW-1:0]   bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             hold_last;

    assign hold_last     = (hold_cnt == HOLD_LAST);
    // Ready is combinational so a new word can be taken in the done cycle.
    assign up.data_ready = (state == StIdle) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            hold_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sig_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (up.data_valid) begin
                        shift_reg <= up.data_in;
                        hold_cnt  <= '0;
                        bit_cnt   <= '0;
                        state     <= StStart;
                        sig_out   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StStart: begin
                    if (hold_last) begin
                        state     <= StData;
                        sig_out   <= shift_reg[WIDTH-1];
                        shift_reg <= shift_reg << 1;
                        hold_cnt  <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (hold_last) begin
                        hold_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state   <= StStop;
                            sig_out <= 1'b0;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            sig_out   <= shift_reg[WIDTH-1];
                            shift_reg <= shift_reg << 1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (hold_last) begin
                        state    <= StIdle;
                        hold_cnt <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
